// File: rtl/l2_line_responder.sv
// L2 responder for the L1 line interface: serves 512-bit line reads and absorbs
// line writebacks from a direct-indexed store, each with its own fixed latency.
module l2_line_responder #(
    parameter int LINE_COUNT     = 256,
    parameter int BYTES_PER_LINE = 64,
    parameter int INDEX_SIZE     = $clog2(LINE_COUNT),
    parameter int READ_LATENCY   = 4,
    parameter int WRITE_LATENCY  = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [63:0]  L2_S_R_ADDR,
    input  logic         L2_S_R_ADDR_VALID,
    output logic [511:0] L2_S_R_DATA,
    output logic         L2_S_R_DATA_VALID,
    input  logic         L2_S_W_VALID,
    input  logic [63:0]  L2_S_W_ADDR,
    input  logic [511:0] L2_S_W_DATA,
    output logic         L2_S_W_READY,
    output logic         L2_S_W_COMPLETE
);

    localparam int OFFSET_SIZE = $clog2(BYTES_PER_LINE);
    localparam int MAX_LAT     = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W       = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_BUSY, W_DONE} w_state_e;

    r_state_e               r_state_q, r_state_d;
    logic [CNT_W-1:0]       r_cnt_q, r_cnt_d;
    logic [INDEX_SIZE-1:0]  r_idx_q, r_idx_d;
    logic [511:0]           r_data_q, r_data_d;
    logic                   r_latch;
    logic [INDEX_SIZE-1:0]  r_latch_idx;

    w_state_e               w_state_q, w_state_d;
    logic [CNT_W-1:0]       w_cnt_q, w_cnt_d;
    logic [INDEX_SIZE-1:0]  w_idx_q, w_idx_d;
    logic [511:0]           w_data_q, w_data_d;
    logic                   w_commit;

    logic [511:0]           store_q [LINE_COUNT];
    logic [INDEX_SIZE-1:0]  r_addr_idx, w_addr_idx;
    logic                   unused_addr_bits;

    // Bits outside the index field (offset and upper alias bits) are don't-care.
    assign r_addr_idx       = L2_S_R_ADDR[OFFSET_SIZE+INDEX_SIZE-1:OFFSET_SIZE];
    assign w_addr_idx       = L2_S_W_ADDR[OFFSET_SIZE+INDEX_SIZE-1:OFFSET_SIZE];
    assign unused_addr_bits = ^{L2_S_R_ADDR, L2_S_W_ADDR};

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        r_state_d   = r_state_q;
        r_cnt_d     = r_cnt_q;
        r_idx_d     = r_idx_q;
        r_data_d    = r_data_q;
        r_latch     = 1'b0;
        r_latch_idx = r_idx_q;
        unique case (r_state_q)
            R_IDLE: if (L2_S_R_ADDR_VALID) begin
                r_idx_d = r_addr_idx;
                if (READ_LATENCY == 1) begin
                    r_latch     = 1'b1;
                    r_latch_idx = r_addr_idx;
                    r_state_d   = R_RESP;
                end else begin
                    r_cnt_d   = R_LOAD;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: if (r_cnt_q == '0) begin
                r_latch   = 1'b1;
                r_state_d = R_RESP;
            end else begin
                r_cnt_d = r_cnt_q - 1'b1;
            end
            R_RESP:  r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
        // A commit landing on the same edge as the read latch forwards its data.
        if (r_latch)
            r_data_d = (w_commit && (w_idx_q == r_latch_idx)) ? w_data_q : store_q[r_latch_idx];
    end

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        w_idx_d   = w_idx_q;
        w_data_d  = w_data_q;
        w_commit  = 1'b0;
        unique case (w_state_q)
            W_IDLE: if (L2_S_W_VALID) begin
                w_idx_d   = w_addr_idx;
                w_data_d  = L2_S_W_DATA;
                w_cnt_d   = W_LOAD;
                w_state_d = W_BUSY;
            end
            W_BUSY: if (w_cnt_q == '0) begin
                w_commit  = 1'b1;
                w_state_d = W_DONE;
            end else begin
                w_cnt_d = w_cnt_q - 1'b1;
            end
            W_DONE:  w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            r_data_q  <= '0;
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            w_idx_q   <= '0;
            w_data_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_idx_q   <= r_idx_d;
            r_data_q  <= r_data_d;
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            w_idx_q   <= w_idx_d;
            w_data_q  <= w_data_d;
        end
    end

    // NOTE: the store is cleared on reset, so it is built from flops rather than an inferred RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LINE_COUNT; i++)
                store_q[i] <= '0;
        end else if (w_commit) begin
            store_q[w_idx_q] <= w_data_q;
        end
    end

    assign L2_S_R_DATA       = reset ? '0 : r_data_q;
    assign L2_S_R_DATA_VALID = (r_state_q == R_RESP) && !reset;
    assign L2_S_W_READY      = (w_state_q == W_IDLE) && !reset;
    assign L2_S_W_COMPLETE   = (w_state_q == W_DONE) && !reset;

endmodule

// File: tb/tb_l2_line_responder.sv
// Directed bench for l2_line_responder (16 lines, read latency 3, write latency 2);
// pulses are logged with their cycle numbers and compared against hand-computed edges.
module tb_l2_line_responder;

    localparam int LC = 16;
    localparam int RL = 3;
    localparam int WL = 2;

    localparam logic [511:0] PAT  = {8{64'hDEADBEEF00000001}};
    localparam logic [511:0] PAT2 = {8{64'h0123456789ABCDEF}};
    localparam logic [511:0] VAL_A = {8{64'hAAAA1111AAAA1111}};
    localparam logic [511:0] VAL_B = {8{64'hBBBB2222BBBB2222}};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [63:0]  r_addr = '0;
    logic         r_valid = 1'b0;
    logic [511:0] r_data;
    logic         r_data_valid;
    logic         w_valid = 1'b0;
    logic [63:0]  w_addr = '0;
    logic [511:0] w_data = '0;
    logic         w_ready;
    logic         w_complete;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int           rv_cyc [$];
    logic [511:0] rv_dat [$];
    int           wc_cyc [$];

    l2_line_responder #(
        .LINE_COUNT(LC), .BYTES_PER_LINE(64), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .clk(clk), .reset(reset),
        .L2_S_R_ADDR(r_addr), .L2_S_R_ADDR_VALID(r_valid),
        .L2_S_R_DATA(r_data), .L2_S_R_DATA_VALID(r_data_valid),
        .L2_S_W_VALID(w_valid), .L2_S_W_ADDR(w_addr), .L2_S_W_DATA(w_data),
        .L2_S_W_READY(w_ready), .L2_S_W_COMPLETE(w_complete)
    );

    always #5 clk = ~clk;

    // cyc == n during the cycle that follows posedge number n.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (r_data_valid) begin
            rv_cyc.push_back(cyc);
            rv_dat.push_back(r_data);
        end
        if (w_complete) wc_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [511:0] data, output int h);
        @(negedge clk);
        w_addr  = addr;
        w_data  = data;
        w_valid = 1'b1;
        h       = cyc + 1;
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    task automatic write_wait(input logic [63:0] addr, input logic [511:0] data);
        int h;
        do_write(addr, data, h);
        repeat (4) @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [63:0] addr, input logic [511:0] exp);
        int e0;
        rv_cyc.delete();
        rv_dat.delete();
        @(negedge clk);
        r_addr  = addr;
        r_valid = 1'b1;
        e0      = cyc + 1;
        @(negedge clk);
        r_valid = 1'b0;
        repeat (5) @(negedge clk);
        check({tag, "_pulses"}, rv_cyc.size(), 1);
        if (rv_cyc.size() > 0) begin
            check({tag, "_cycle"}, rv_cyc[0], e0 + RL);
            check({tag, "_data"}, rv_dat[0], exp);
        end
    endtask

    initial begin
        int h;
        int e0;
        int c0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_rvalid", r_data_valid, 1'b0);
        check("rst_rdata", r_data, '0);
        check("rst_complete", w_complete, 1'b0);
        check("rst_ready", w_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_ready", w_ready, 1'b1);

        // Cold read returns zero after exactly RL edges, one pulse
        read_check("rd_cold_40", 64'h40, '0);

        // Write handshake timing
        wc_cyc.delete();
        do_write(64'h80, PAT, h);
        check("wr_ready_low_h", w_ready, 1'b0);
        @(negedge clk);
        check("wr_ready_low_h1", w_ready, 1'b0);
        @(negedge clk);
        check("wr_complete_h2", w_complete, 1'b1);
        @(negedge clk);
        check("wr_ready_back", w_ready, 1'b1);
        check("wr_complete_gone", w_complete, 1'b0);
        check("wr_complete_count", wc_cyc.size(), 1);
        if (wc_cyc.size() > 0) check("wr_complete_cycle", wc_cyc[0], h + WL);

        read_check("rd_80", 64'h80, PAT);
        read_check("rd_alias_480", 64'h480, PAT);
        read_check("rd_offset_9c", 64'h9C, PAT);
        repeat (3) @(negedge clk);
        check("rdata_holds", r_data, PAT);

        // Same-edge commit and read latch: forwarded write data
        write_wait(64'h100, VAL_A);
        rv_cyc.delete();
        rv_dat.delete();
        @(negedge clk);
        r_addr  = 64'h100;
        r_valid = 1'b1;
        e0      = cyc + 1;
        @(negedge clk);
        r_valid = 1'b0;
        w_addr  = 64'h100;
        w_data  = VAL_B;
        w_valid = 1'b1;
        @(negedge clk);
        w_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("fwd_pulses", rv_cyc.size(), 1);
        if (rv_cyc.size() > 0) begin
            check("fwd_cycle", rv_cyc[0], e0 + RL);
            check("fwd_data", rv_dat[0], VAL_B);
        end

        // Read latched one edge before the commit sees the old line
        write_wait(64'h100, VAL_A);
        rv_cyc.delete();
        rv_dat.delete();
        @(negedge clk);
        r_addr  = 64'h100;
        r_valid = 1'b1;
        e0      = cyc + 1;
        @(negedge clk);
        r_valid = 1'b0;
        @(negedge clk);
        w_addr  = 64'h100;
        w_data  = VAL_B;
        w_valid = 1'b1;
        @(negedge clk);
        w_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("early_pulses", rv_cyc.size(), 1);
        if (rv_cyc.size() > 0) check("early_data", rv_dat[0], VAL_A);
        read_check("rd_after_commit", 64'h100, VAL_B);

        // Valid held high for 12 cycles: captures every RL+2 edges
        rv_cyc.delete();
        rv_dat.delete();
        @(negedge clk);
        r_addr  = 64'h40;
        r_valid = 1'b1;
        c0      = cyc + 1;
        repeat (12) @(negedge clk);
        r_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("stream_pulses", rv_cyc.size(), 3);
        for (int i = 0; i < rv_cyc.size() && i < 3; i++) begin
            check($sformatf("stream_cycle%0d", i), rv_cyc[i], c0 + RL + 5 * i);
            check($sformatf("stream_data%0d", i), rv_dat[i], '0);
        end

        // Reset while the write is busy: no completion, write lost
        wc_cyc.delete();
        do_write(64'hC0, PAT2, h);
        reset = 1'b1;
        #1;
        check("abort_ready_in_rst", w_ready, 1'b0);
        check("abort_rdata_in_rst", r_data, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready_after", w_ready, 1'b1);
        repeat (5) @(negedge clk);
        check("abort_no_complete", wc_cyc.size(), 0);
        read_check("rd_aborted_c0", 64'hC0, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
